fetch_pc_unit: RTL and testbench

//   Instruction-fetch front end of the RISC-V core. Holds the architectural fetch PC, computes the next

---
 rtl/fetch_pc_unit_pkg.sv | 26 ++
 rtl/fetch_next_pc.sv | 39 +++
 rtl/fetch_pc_unit.sv | 98 +++++++++
 tb/tb_fetch_pc_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared core constants and types for the instruction-fetch front end.
// Optional perf counters in fetch_pc_unit are enabled by defining FETCH_PERF_CNT_EN.
package fetch_pc_unit_pkg;

   localparam int unsigned PcWidth    = 32;
   localparam int unsigned InstrWidth = 32;

   localparam logic [PcWidth-1:0]    ResetPc  = 32'h4000_0000;
   localparam logic [InstrWidth-1:0] NopInstr = 32'h0000_0013;

   // Fetch increment and word-alignment mask.
   localparam logic [PcWidth-1:0] PcStep    = 32'h0000_0004;
   localparam logic [PcWidth-1:0] WordAlign = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      NpcReset,
      NpcRedirect,
      NpcHold,
      NpcSeq
   } npc_sel_e;

   function automatic logic [PcWidth-1:0] word_align(input logic [PcWidth-1:0] addr);
      return addr & WordAlign;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-fetch-address select: reset > redirect > stall > sequential.
module fetch_next_pc
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [PcWidth-1:0] RESET_PC = ResetPc
) (
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [PcWidth-1:0] redirect_pc_i,
   input  logic [PcWidth-1:0] pc_i,
   output logic [PcWidth-1:0] next_pc_o
);

   npc_sel_e sel;

   always_comb begin
      sel = NpcSeq;
      if (rst_i) begin
         sel = NpcReset;
      end else if (redirect_i) begin
         sel = NpcRedirect;
      end else if (stall_i) begin
         sel = NpcHold;
      end
   end

   always_comb begin
      next_pc_o = pc_i + PcStep;
      unique case (sel)
         NpcReset:    next_pc_o = RESET_PC;
         NpcRedirect: next_pc_o = word_align(redirect_pc_i);
         NpcHold:     next_pc_o = pc_i;
         NpcSeq:      next_pc_o = pc_i + PcStep;
         default:     next_pc_o = pc_i + PcStep;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: fetch PC, sync IMEM address, squash of wrong-path instruction.
// Define FETCH_PERF_CNT_EN to add fetch_count_o / redirect_count_o performance counters.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [PcWidth-1:0]    RESET_PC  = ResetPc,
   parameter logic [InstrWidth-1:0] NOP_INSTR = NopInstr
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [PcWidth-1:0]    redirect_pc_i,
   output logic [PcWidth-1:0]    imem_addr_o,
   input  logic [InstrWidth-1:0] imem_rdata_i,
   output logic [PcWidth-1:0]    pc_out_o,
   output logic [InstrWidth-1:0] inst_out_o,
   output logic                  inst_valid_o,
   output logic                  misalign_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_count_o,
   output logic [31:0]           redirect_count_o
`endif
);

   logic [PcWidth-1:0] pc_q, pc_d;
   logic               valid_q;
   logic               misalign_q, misalign_d;
   logic               inst_valid;

   fetch_next_pc #(
      .RESET_PC(RESET_PC)
   ) u_next_pc (
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .pc_i         (pc_q),
      .next_pc_o    (pc_d)
   );

   assign misalign_d = redirect_i & (|redirect_pc_i[1:0]);

   // pc_q resets one word below RESET_PC so the sequential path fetches RESET_PC first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC - PcStep;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         valid_q    <= 1'b1;
         misalign_q <= misalign_d;
      end
   end

   // The instruction visible during a redirect cycle is wrong-path.
   assign inst_valid = valid_q & ~redirect_i;

   always_comb begin
      imem_addr_o  = pc_d;
      pc_out_o     = pc_q;
      inst_valid_o = inst_valid;
      inst_out_o   = inst_valid ? imem_rdata_i : NOP_INSTR;
      misalign_o   = misalign_q;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] redirect_count_q, redirect_count_d;

   always_comb begin
      fetch_count_d    = fetch_count_q;
      redirect_count_d = redirect_count_q;
      if (inst_valid && !stall_i) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
      if (redirect_i) begin
         redirect_count_d = redirect_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_count_q    <= 32'd0;
         redirect_count_q <= 32'd0;
      end else begin
         fetch_count_q    <= fetch_count_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign fetch_count_o    = fetch_count_q;
   assign redirect_count_o = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, reset corner case, random run.
module tb_fetch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h4000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] inst_out;
   logic        inst_valid;
   logic        misalign;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] redirect_count;
`endif

   int total = 0;
   int bad   = 0;

   fetch_pc_unit dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .stall_i         (stall),
      .redirect_i      (redirect),
      .redirect_pc_i   (redirect_pc),
      .imem_addr_o     (imem_addr),
      .imem_rdata_i    (imem_rdata),
      .pc_out_o        (pc_out),
      .inst_out_o      (inst_out),
      .inst_valid_o    (inst_valid),
      .misalign_o      (misalign)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count_o   (fetch_count),
      .redirect_count_o(redirect_count)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A00_0001;
   endfunction

   always @(posedge clk) imem_rdata <= mem_word(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic [31:0] exp_addr;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[19];

   // Reference model state: PC of the instruction on display, whether it is live, misalign flag.
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_mis;
   logic [31:0] m_fc;
   logic [31:0] m_rc;

   initial begin
      vecs[0]  = '{0, 0, 32'h0, 32'h4000_0000, 32'h3FFF_FFFC, 0, 0};
      vecs[1]  = '{0, 0, 32'h0, 32'h4000_0004, 32'h4000_0000, 1, 0};
      vecs[2]  = '{0, 0, 32'h0, 32'h4000_0008, 32'h4000_0004, 1, 0};
      vecs[3]  = '{1, 0, 32'h0, 32'h4000_0008, 32'h4000_0008, 1, 0};
      vecs[4]  = '{1, 0, 32'h0, 32'h4000_0008, 32'h4000_0008, 1, 0};
      vecs[5]  = '{1, 0, 32'h0, 32'h4000_0008, 32'h4000_0008, 1, 0};
      vecs[6]  = '{0, 0, 32'h0, 32'h4000_000C, 32'h4000_0008, 1, 0};
      vecs[7]  = '{0, 0, 32'h0, 32'h4000_0010, 32'h4000_000C, 1, 0};
      vecs[8]  = '{1, 1, 32'h1000_0040, 32'h1000_0040, 32'h4000_0010, 0, 0};
      vecs[9]  = '{0, 0, 32'h0, 32'h1000_0044, 32'h1000_0040, 1, 0};
      vecs[10] = '{0, 1, 32'h1000_0042, 32'h1000_0040, 32'h1000_0044, 0, 0};
      vecs[11] = '{0, 0, 32'h0, 32'h1000_0044, 32'h1000_0040, 1, 1};
      vecs[12] = '{0, 0, 32'h0, 32'h1000_0048, 32'h1000_0044, 1, 0};
      vecs[13] = '{0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h1000_0048, 0, 0};
      vecs[14] = '{0, 0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 0};
      vecs[15] = '{0, 0, 32'h0, 32'h0000_0004, 32'h0000_0000, 1, 0};
      vecs[16] = '{0, 1, 32'h2000_0000, 32'h2000_0000, 32'h0000_0004, 0, 0};
      vecs[17] = '{0, 1, 32'h3000_0000, 32'h3000_0000, 32'h2000_0000, 0, 0};
      vecs[18] = '{0, 0, 32'h0, 32'h3000_0004, 32'h3000_0000, 1, 0};

      // Reset held across a few edges, released between edges.
      repeat (3) tick();
      chk("reset_pc", pc_out, RST_PC - 32'd4);
      chk("reset_valid", {31'b0, inst_valid}, 32'd0);
      chk("reset_inst", inst_out, NOP);
      chk("reset_addr", imem_addr, RST_PC);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         stall       = vecs[i].stall;
         redirect    = vecs[i].redirect;
         redirect_pc = vecs[i].rpc;
         #3;
         chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
         chk($sformatf("v%0d_pc", i), pc_out, vecs[i].exp_pc);
         chk($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
         chk($sformatf("v%0d_inst", i), inst_out,
             vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : NOP);
         chk($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
         tick();
      end
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
      chk("tbl_fetch_count", fetch_count, 32'd10);
      chk("tbl_redirect_count", redirect_count, 32'd5);
`endif

      // Asynchronous reset mid-stream, between edges.
      #2;
      rst = 1'b1;
      #1;
      chk("async_pc", pc_out, RST_PC - 32'd4);
      chk("async_valid", {31'b0, inst_valid}, 32'd0);
      chk("async_inst", inst_out, NOP);
      chk("async_mis", {31'b0, misalign}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("async_fetch_count", fetch_count, 32'd0);
      chk("async_redirect_count", redirect_count, 32'd0);
`endif
      tick();
      rst = 1'b0;
      #1;
      chk("rel_valid", {31'b0, inst_valid}, 32'd0);
      repeat (6) tick();
      chk("rel_pc", pc_out, 32'h4000_0014);
      chk("rel_inst", inst_out, mem_word(32'h4000_0014));
`ifdef FETCH_PERF_CNT_EN
      chk("rel_fetch_count", fetch_count, 32'd5);
`endif

      // Random run against the reference model.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = RST_PC - 32'd4;
      m_valid = 1'b0;
      m_mis = 1'b0;
      m_fc = 32'd0;
      m_rc = 32'd0;
      for (int n = 0; n < 400; n++) begin
         logic [31:0] e_addr;
         logic        e_valid;
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 6) == 0);
         redirect_pc = $urandom;
         if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFFC | (redirect_pc & 32'h3);
         #3;
         if (redirect) e_addr = {redirect_pc[31:2], 2'b00};
         else if (stall) e_addr = m_pc;
         else e_addr = m_pc + 32'd4;
         e_valid = m_valid && !redirect;
         chk("rnd_addr", imem_addr, e_addr);
         chk("rnd_pc", pc_out, m_pc);
         chk("rnd_valid", {31'b0, inst_valid}, {31'b0, e_valid});
         chk("rnd_inst", inst_out, e_valid ? mem_word(m_pc) : NOP);
         chk("rnd_mis", {31'b0, misalign}, {31'b0, m_mis});
`ifdef FETCH_PERF_CNT_EN
         chk("rnd_fetch_count", fetch_count, m_fc);
         chk("rnd_redirect_count", redirect_count, m_rc);
`endif
         if (e_valid && !stall) m_fc = m_fc + 32'd1;
         if (redirect) m_rc = m_rc + 32'd1;
         m_mis = redirect && (redirect_pc[1:0] != 2'b00);
         m_pc = e_addr;
         m_valid = 1'b1;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
